// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller: FSM encoding,
// increment constant and the word-alignment helper.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_INC  = 32'd4;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/PCmux.sv
// Next-PC source select: redirect/pending target when PCSel=1, else pc+4.
module PCmux (
    input  logic        PCSel,
    input  logic [31:0] alu,
    input  logic [31:0] pc_plus4,
    output logic [31:0] pc_next
);

    assign pc_next = PCSel ? alu : pc_plus4;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC controller: sequences the fetch address through a
// post-reset idle cycle, holds on stall/backpressure, and parks redirects
// that arrive while the instruction memory is not accepting.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_BOOT | one idle cycle after reset, no fetch request, redirects ignored
// ST_RUN  | fetching sequentially, pc advances on accept unless stalled
// ST_PEND | fetching, a redirect target waits in pend_q for the next accept
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        pc_sel,
    output logic        imem_req,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        misalign_err,
    output logic [15:0] redirect_cnt
);

    pc_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic [15:0] cnt_q;
    logic        imem_req_q;

    logic        running;
    logic        redir;
    logic        accept;
    logic        load_pc;
    logic [31:0] tgt_aligned;
    logic [31:0] mux_alu;
    logic [31:0] pc_d;

    // Reset gates every combinational output so nothing leaks out while rst is held.
    assign running     = !rst && (state_q != ST_BOOT);
    assign redir       = running && redirect_valid;
    assign imem_req    = imem_req_q && !rst;
    assign accept      = imem_req && imem_ready;
    assign tgt_aligned = align_word(redirect_target);

    assign pc_sel   = redir || (running && (state_q == ST_PEND));
    assign mux_alu  = redir ? tgt_aligned : pend_q;
    assign pc_plus4 = pc_q + PC_INC;

    // A redirect or pending target overrides stall; sequential advance does not.
    assign load_pc = accept && (pc_sel || !stall);

    PCmux u_pcmux (
        .PCSel    (pc_sel),
        .alu      (mux_alu),
        .pc_plus4 (pc_plus4),
        .pc_next  (pc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 32'd0;
            cnt_q      <= 16'd0;
            imem_req_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_RUN;
                    imem_req_q <= 1'b1;
                end
                ST_RUN, ST_PEND: begin
                    if (load_pc) begin
                        pc_q <= pc_d;
                    end
                    if (redir && !accept) begin
                        pend_q  <= tgt_aligned;
                        state_q <= ST_PEND;
                    end else if (accept) begin
                        state_q <= ST_RUN;
                    end
                    if (redir && (cnt_q != CNT_MAX)) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q    <= ST_BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign flush_if_id  = redir;
    assign flush_id_ex  = redir;
    assign misalign_err = redir && (redirect_target[1:0] != 2'b00);
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: the driver predicts each cycle's outputs from
// a behavioural model and queues them; the monitor compares what the DUT shows.
module tb_pc_ctrl;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_sel;
    logic        imem_req;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misalign_err;
    logic [15:0] redirect_cnt;

    pc_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_ready      (imem_ready),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .pc_sel          (pc_sel),
        .imem_req        (imem_req),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .misalign_err    (misalign_err),
        .redirect_cnt    (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        known;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        pc_sel;
        logic        req;
        logic        flush;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model: what the fetch stage should be doing, as plain flags.
    logic        m_known      = 1'b0;
    logic        m_in_boot    = 1'b1;
    logic        m_have_pend  = 1'b0;
    logic [31:0] m_pend       = 32'd0;
    logic [31:0] m_pc         = 32'd0;
    int          m_cnt        = 0;
    logic        driver_done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic rv,
                       input logic [31:0] t, input logic rdy);
        exp_t e;
        logic live;
        logic acc;
        logic [31:0] t_al;
        @(negedge clk);
        rst             = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = t;
        imem_ready      = rdy;

        live       = !r && !m_in_boot;
        t_al       = t & 32'hFFFF_FFFC;
        e.known    = m_known;
        e.pc       = m_pc;
        e.pc_plus4 = m_pc + 32'd4;
        e.req      = live;
        e.flush    = live && rv;
        e.mis      = live && rv && (t % 4 != 0);
        e.pc_sel   = live && (rv || m_have_pend);
        e.cnt      = m_cnt[15:0];
        exp_q.push_back(e);

        acc = live && rdy;
        if (r) begin
            m_known     = 1'b1;
            m_in_boot   = 1'b1;
            m_have_pend = 1'b0;
            m_pend      = 32'd0;
            m_pc        = TB_RESET_PC;
            m_cnt       = 0;
        end else if (m_in_boot) begin
            m_in_boot = 1'b0;
        end else if (rv) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (acc) begin
                m_pc        = t_al;
                m_have_pend = 1'b0;
            end else begin
                m_pend      = t_al;
                m_have_pend = 1'b1;
            end
        end else if (m_have_pend) begin
            if (acc) begin
                m_pc        = m_pend;
                m_have_pend = 1'b0;
            end
        end else if (acc && !s) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("imem_req",     {31'd0, imem_req},     {31'd0, e.req});
            check("flush_if_id",  {31'd0, flush_if_id},  {31'd0, e.flush});
            check("flush_id_ex",  {31'd0, flush_id_ex},  {31'd0, e.flush});
            check("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
            check("pc_sel",       {31'd0, pc_sel},       {31'd0, e.pc_sel});
            if (e.known) begin
                check("pc",           pc,                    e.pc);
                check("pc_plus4",     pc_plus4,              e.pc_plus4);
                check("redirect_cnt", {16'd0, redirect_cnt}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'd0; imem_ready = 1'b1;

        // Reset release then sequential fetch 0,4,8,C,10
        repeat (2) cyc(1, 0, 0, 32'd0, 1);
        repeat (5) cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 1, 32'h100, 1);
        cyc(0, 0, 0, 32'd0, 1);
        // Redirect beats stall; plain stall holds
        cyc(0, 1, 1, 32'h200, 1);
        repeat (2) cyc(0, 1, 0, 32'd0, 1);
        // Back-to-back redirects under backpressure, newest wins
        cyc(0, 0, 1, 32'h300, 0);
        cyc(0, 0, 1, 32'h400, 0);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        // Misaligned target
        cyc(0, 0, 1, 32'h102, 1);
        cyc(0, 0, 0, 32'd0, 1);
        // Wrap at top of address space
        cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
        repeat (2) cyc(0, 0, 0, 32'd0, 1);
        // Redirect during BOOT is ignored
        cyc(1, 0, 0, 32'd0, 1);
        cyc(0, 0, 1, 32'h600, 1);
        cyc(0, 0, 0, 32'd0, 1);
        // Reset while a redirect is pending discards it
        cyc(0, 0, 1, 32'h500, 0);
        cyc(0, 1, 0, 32'd0, 0);
        repeat (2) cyc(1, 0, 0, 32'd0, 1);
        repeat (4) cyc(0, 0, 0, 32'd0, 1);

        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end

        // Saturation of redirect_cnt from zero
        repeat (2) cyc(1, 0, 0, 32'd0, 1);
        for (int i = 0; i < 65540; i++) begin
            cyc(0, 0, 1, $urandom, ($urandom_range(0, 1) == 1));
        end
        repeat (3) cyc(0, 0, 0, 32'd0, 1);

        driver_done = 1'b1;
        w = 0;
        while (exp_q.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        #4;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hazard-unit freeze of the fetch stage (load-use).
REQ-005 SHALL have port redirect_valid  input  1  branch/jump resolved taken in EX.
REQ-006 SHALL have port redirect_target  input  32  redirect address from the ALU.
REQ-007 SHALL have port imem_ready  input  1  instruction memory accepts the current request.
REQ-008 SHALL have port pc  output  32  current fetch address.
REQ-009 SHALL have port pc_plus4  output  32  pc + 4.
REQ-010 SHALL have port pc_sel  output  1  next-PC source: 1 = redirect target, 0 = pc_plus4.
REQ-011 SHALL have port imem_req  output  1  fetch request valid.
REQ-012 SHALL have port flush_if_id  output  1  clear the IF/ID register at the next edge.
REQ-013 SHALL have port flush_id_ex  output  1  clear the ID/EX register at the next edge.
REQ-014 SHALL have port misalign_err  output  1  one-cycle pulse for a redirect target with bits [1:0] != 0.
REQ-015 SHALL have port redirect_cnt  output  16  count of accepted redirects, saturating.

Function
REQ-016 SHALL implement three states:
- BOOT: imem_req=0 for exactly one cycle after reset, then go to RUN.
- RUN: imem_req=1.
- PEND: imem_req=1, with a redirect held in pend_target.
REQ-017 SHALL advance pc only on an "accept" cycle, defined as imem_req && imem_ready.
REQ-018 SHALL, in RUN with accept && !stall && !redirect_valid, load pc <= pc_plus4 with pc_sel=0.
REQ-019 SHALL hold pc when stall=1 or imem_ready=0 and there is no redirect; the request stays stable until accepted.
REQ-020 SHALL give redirect_valid priority over stall: with accept, load pc <= {redirect_target[31:2],2'b00} and set pc_sel=1.
REQ-021 SHALL, on redirect_valid without accept, latch the aligned target into pend_target and go to PEND; pc is unchanged.
REQ-022 SHALL, in PEND with a new redirect_valid, overwrite pend_target (newest wins).
REQ-023 SHALL, in PEND on accept (stall ignored), load pc <= pend_target, set pc_sel=1 and return to RUN.
  - If a new redirect arrives in that same cycle, it wins and the state stays RUN.
REQ-024 SHALL drive flush_if_id and flush_id_ex combinationally high in every cycle redirect_valid=1 (not in BOOT), regardless of stall or imem_ready.
REQ-025 SHALL pulse misalign_err in the cycle a redirect with redirect_target[1:0] != 0 is sampled; the target is still used with bits [1:0] forced to 0.
REQ-026 SHALL increment redirect_cnt once per cycle in which redirect_valid=1 outside BOOT, saturating at 16'hFFFF.
REQ-027 SHALL compute pc_plus4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 SHALL ignore redirect_valid during BOOT: no flush, no count, no latch.

Reset
REQ-029 SHALL, while rst=1, set pc=RESET_PC, state=BOOT, pend_target=0, redirect_cnt=0, imem_req=0, pc_sel=0, flush_if_id=0, flush_id_ex=0, misalign_err=0.
REQ-030 SHALL discard any pending redirect when reset is asserted mid-operation.

Structure
REQ-031 SHALL place the state encoding (BOOT/RUN/PEND) and the 32'd4 increment constant in the shared core package.
REQ-032 SHALL instantiate the existing PCmux (PCSel=pc_sel, alu=selected redirect or pend target, pc_plus4) as its single sub-module for next-PC selection.

Verification
REQ-033 Reset release: rst=1 for 2 cycles, imem_ready=1, stall=0 -> imem_req=0 for one cycle, then pc=0x0,0x4,0x8,0xC.
REQ-034 Redirect at pc=0x10, target 0x100 -> flush_if_id=flush_id_ex=1 and pc_sel=1 that cycle; next pc=0x100; redirect_cnt=1.
REQ-035 stall=1 with redirect 0x200 in the same cycle -> next pc=0x200; with stall=1 and no redirect, pc holds.
REQ-036 imem_ready=0: redirects 0x300 then 0x400 on consecutive cycles, imem_ready=1 on the third -> pc holds, then becomes 0x400; redirect_cnt increases by 2.
REQ-037 Redirect target 0x102 -> misalign_err=1 for one cycle; next pc=0x100.
REQ-038 Boundaries:
  - pc=0xFFFF_FFFC advancing -> pc=0x0.
  - redirect_cnt preloaded to 0xFFFF plus one redirect -> stays 0xFFFF.
  - rst in PEND -> pc=RESET_PC and the pending target is never loaded.
